// File: rtl/macro_psum_acc_pkg.sv
// Shared defaults and types for the CIM macro partial-sum accumulator.
// Holds the lane/accumulator widths and the accumulator width rule.
// No logic lives here; imported by the interface, lane and top.
package macro_psum_acc_pkg;

  localparam int MACRO_O_DW_DEF = 8;
  localparam int N_OCH_DEF      = 64;
  localparam int N_GROUP_DEF    = 4;

  // Minimum accumulator width that cannot overflow when n_group signed
  // o_dw-bit values are summed.
  function automatic int acc_dw(input int o_dw, input int n_group);
    return o_dw + $clog2(n_group);
  endfunction

  typedef logic signed [MACRO_O_DW_DEF-1:0]                           lane_t;
  typedef logic signed [acc_dw(MACRO_O_DW_DEF, N_GROUP_DEF)-1:0]      acc_t;

endpackage

// File: rtl/macro_psum_acc_if.sv
// Stream bundle between the macro, the accumulator and the next layer.
// in_*  : one macro result per beat (valid/ready), lane i = output channel i.
// out_* : one binary activation vector per pixel (valid/ready).
interface macro_psum_acc_if #(
  parameter int MACRO_O_DW = 8,
  parameter int N_OCH      = 64
);
  logic                                in_valid;
  logic                                in_ready;
  logic [N_OCH-1:0][MACRO_O_DW-1:0]    in_data;
  logic                                out_valid;
  logic                                out_ready;
  logic [N_OCH-1:0]                    out_act;

  // master drives macro results and consumes activations (macro + next layer side)
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_act
  );

  // slave is the accumulator stage itself
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_act
  );
endinterface

// File: rtl/macro_psum_acc_lane.sv
// One output channel: accumulator register, adder and threshold compare.
// Ports: first (restart from 0), acc_en (store sum), in_lane, thr -> act.
// Combinational sum/compare; acc updates one cycle after an enabled beat.
module macro_psum_acc_lane #(
  parameter int I_DW = 8,
  parameter int A_DW = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   first,
  input  logic                   acc_en,
  input  logic signed [I_DW-1:0] in_lane,
  input  logic signed [A_DW-1:0] thr,
  output logic                   act
);

  logic signed [A_DW-1:0] acc;
  logic signed [A_DW-1:0] ext;
  logic signed [A_DW-1:0] base;
  logic signed [A_DW-1:0] s;

  // Signed cast to the wider type sign-extends the lane value.
  assign ext  = A_DW'(in_lane);
  // The first group ignores whatever is left in acc, so acc never needs clearing.
  assign base = first ? '0 : acc;
  assign s    = base + ext;
  // Equality counts as +1.
  assign act  = (s >= thr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (acc_en) begin
      acc <= s;
    end
  end

endmodule

// File: rtl/macro_psum_acc.sv
// Accumulates N_GROUP macro results per lane, binarises vs thr, emits N_OCH-bit act.
// Ports: clk, rst_n, sync_clr, bus (slave stream), thr (per-lane), grp_cnt (debug).
// Latency 1 cycle after last beat; in_ready drops only while a pixel is held unaccepted.
module macro_psum_acc
  import macro_psum_acc_pkg::*;
#(
  parameter int MACRO_O_DW = MACRO_O_DW_DEF,
  parameter int N_OCH      = N_OCH_DEF,
  parameter int N_GROUP    = N_GROUP_DEF,
  parameter int ACC_DW     = acc_dw(MACRO_O_DW, N_GROUP),
  localparam int GW        = (N_GROUP > 1) ? $clog2(N_GROUP) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sync_clr,
  macro_psum_acc_if.slave              bus,
  input  logic [N_OCH-1:0][ACC_DW-1:0] thr,
  output logic [GW-1:0]                grp_cnt
);

  if (ACC_DW < acc_dw(MACRO_O_DW, N_GROUP)) begin : g_acc_dw_check
    $error("macro_psum_acc: ACC_DW too small for MACRO_O_DW and N_GROUP");
  end

  localparam logic [GW-1:0] LAST_GRP = GW'(N_GROUP - 1);

  logic             out_valid_q;
  logic [N_OCH-1:0] out_act_q;
  logic [N_OCH-1:0] act;
  logic             beat;
  logic             take;
  logic             first;
  logic             last;

  assign bus.in_ready  = !(out_valid_q && !bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.out_act   = out_act_q;

  assign beat  = bus.in_valid && bus.in_ready;
  // sync_clr wins over a coincident beat: the beat's data is dropped.
  assign take  = beat && !sync_clr;
  assign first = (grp_cnt == '0);
  // With N_GROUP==1 grp_cnt is stuck at 0 so every beat is both first and last.
  assign last  = (grp_cnt == LAST_GRP);

  for (genvar i = 0; i < N_OCH; i++) begin : g_lane
    macro_psum_acc_lane #(
      .I_DW (MACRO_O_DW),
      .A_DW (ACC_DW)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .first   (first),
      .acc_en  (take && !last),
      .in_lane (bus.in_data[i]),
      .thr     (thr[i]),
      .act     (act[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grp_cnt <= '0;
    end else if (sync_clr) begin
      grp_cnt <= '0;
    end else if (take) begin
      grp_cnt <= last ? '0 : grp_cnt + GW'(1);
    end
  end

  // A last beat taken in the same cycle as out_ready keeps out_valid high
  // and replaces out_act, giving back-to-back pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_act_q   <= '0;
    end else if (take && last) begin
      out_valid_q <= 1'b1;
      out_act_q   <= act;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_macro_psum_acc.sv
module tb_macro_psum_acc;

  localparam int DW = 8;
  localparam int NO = 64;
  localparam int NG = 4;
  localparam int AW = 10;

  typedef logic [NO-1:0][DW-1:0] data_t;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     sync_clr = 1'b0;
  logic [NO-1:0][AW-1:0]    thr;
  logic [1:0]               grp_cnt;

  macro_psum_acc_if #(.MACRO_O_DW(DW), .N_OCH(NO)) bus ();

  macro_psum_acc #(
    .MACRO_O_DW (DW),
    .N_OCH      (NO),
    .N_GROUP    (NG),
    .ACC_DW     (AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sync_clr (sync_clr),
    .bus      (bus.slave),
    .thr      (thr),
    .grp_cnt  (grp_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: per-pixel integer sums, group count, held output.
  int          m_sum [NO];
  int          m_grp;
  bit          m_ov;
  logic [NO-1:0] m_act;
  int          thr_m [NO];
  bit          last_ov;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic data_t rnd_data();
    data_t r;
    for (int i = 0; i < NO; i++) r[i] = DW'($urandom);
    return r;
  endfunction

  task automatic apply_thr();
    for (int i = 0; i < NO; i++) begin
      int t;
      t = thr_m[i];
      thr[i] = t[AW-1:0];
    end
  endtask

  task automatic rnd_thr();
    for (int i = 0; i < NO; i++) thr_m[i] = $urandom_range(0, 500) - 250;
    apply_thr();
  endtask

  // One clock cycle: drive, check in_ready, advance model, check outputs.
  task automatic step(input bit v, input data_t d, input bit ordy, input bit clr);
    bit rdy_exp, beat, done;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    sync_clr      = clr;
    #1;
    rdy_exp = !(m_ov && !ordy);
    chk("in_ready", bus.in_ready, rdy_exp);
    beat = v && rdy_exp;
    done = 0;
    if (clr) begin
      m_grp = 0;
    end else if (beat) begin
      for (int i = 0; i < NO; i++)
        m_sum[i] = ((m_grp == 0) ? 0 : m_sum[i]) + int'($signed(d[i]));
      m_grp++;
      if (m_grp == NG) begin
        m_grp = 0;
        done  = 1;
        for (int i = 0; i < NO; i++) m_act[i] = (m_sum[i] >= thr_m[i]);
      end
    end
    if (done) m_ov = 1;
    else if (ordy) m_ov = 0;
    @(posedge clk);
    #1;
    last_ov = bus.out_valid;
    chk("out_valid", bus.out_valid, m_ov);
    chk("out_act", bus.out_act, m_act);
    chk("grp_cnt", grp_cnt, m_grp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = rnd_data();
    bus.out_ready = 1'b0;
    sync_clr      = 1'b0;
    m_ov  = 0;
    m_act = '0;
    m_grp = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_act", bus.out_act, 0);
    chk("rst_grp_cnt", grp_cnt, 0);
    @(negedge clk);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
  endtask

  initial begin
    int seq [4];
    data_t d;
    logic [NO-1:0] act_a;
    logic [11:0] mask;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < NO; i++) m_sum[i] = 0;
    rnd_thr();

    // 1: reset with in_valid held high
    do_reset();

    // 2: directed pixel on lanes 0/1, random elsewhere
    seq = '{10, -3, 7, -20};
    thr_m[0] = -6;
    thr_m[1] = -5;
    apply_thr();
    for (int g = 0; g < NG; g++) begin
      d = rnd_data();
      d[0] = DW'(seq[g]);
      d[1] = DW'(seq[g]);
      step(1, d, 1, 0);
    end
    chk("t2_valid", bus.out_valid, 1);
    chk("t2_lane0", bus.out_act[0], 1);
    chk("t2_lane1", bus.out_act[1], 0);
    step(0, rnd_data(), 1, 0);

    // 3: extremes
    for (int i = 0; i < NO; i++) thr_m[i] = -512;
    apply_thr();
    for (int g = 0; g < NG; g++) begin
      for (int i = 0; i < NO; i++) d[i] = 8'h80;
      step(1, d, 1, 0);
    end
    chk("t3_min_all_ones", bus.out_act, {NO{1'b1}});
    for (int i = 0; i < NO; i++) thr_m[i] = 509;
    apply_thr();
    for (int g = 0; g < NG; g++) begin
      for (int i = 0; i < NO; i++) d[i] = 8'h7f;
      step(1, d, 1, 0);
    end
    chk("t3_max_all_zero", bus.out_act, 0);
    step(0, rnd_data(), 1, 0);

    // 4: backpressure on a held pixel
    rnd_thr();
    for (int g = 0; g < NG; g++) step(1, rnd_data(), 0, 0);
    act_a = m_act;
    for (int k = 0; k < 3; k++) begin
      step(1, rnd_data(), 0, 0);
      chk("t4_stall_ready", bus.in_ready, 0);
      chk("t4_act_stable", bus.out_act, act_a);
    end
    step(1, rnd_data(), 1, 0);
    for (int g = 1; g < NG; g++) step(1, rnd_data(), 0, 0);
    step(1, rnd_data(), 1, 0);
    step(0, rnd_data(), 1, 1);

    // 5: continuous stream, 12 beats -> pulses after beats 4, 8, 12
    mask = '0;
    for (int k = 0; k < 12; k++) begin
      step(1, rnd_data(), 1, 0);
      mask[k] = last_ov;
    end
    chk("t5_pulses", mask, 12'h888);
    step(0, rnd_data(), 1, 0);

    // 6: sync_clr with the third beat
    step(1, rnd_data(), 1, 0);
    step(1, rnd_data(), 1, 0);
    step(1, rnd_data(), 1, 1);
    chk("t6_grp_clr", grp_cnt, 0);
    for (int g = 0; g < NG; g++) step(1, rnd_data(), 1, 0);
    chk("t6_valid", bus.out_valid, 1);

    // reset mid-pixel: partial sums lost, fresh pixel afterwards
    step(1, rnd_data(), 1, 0);
    step(1, rnd_data(), 1, 0);
    do_reset();
    for (int g = 0; g < NG; g++) step(1, rnd_data(), 1, 0);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 49) == 0) rnd_thr();
      step($urandom_range(0, 3) != 0, rnd_data(), $urandom_range(0, 2) != 0,
           $urandom_range(0, 31) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
